// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch stage: IF/ID payload struct,
// fetch FSM state enum and the canonical NOP encoding.
package fetch_ctrl_pkg;

  localparam int unsigned IF_XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [31:0]        instr;
    logic               valid;
  } if_reg_d;

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating event counter used for the fetch-stage performance counters.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Count up on inc, stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues req/ack fetches, drives the
// IF/ID register. Optional performance counters under `FETCH_PERF_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned      XLEN     = IF_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [XLEN-1:0]  PC_STEP  = XLEN'(4)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall_id,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            pc_write,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_bubble_cnt,
`endif
  output if_reg_d         if_reg_in
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [31:0]     hold_q, hold_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // PC, pending redirect target and held instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      pend_q <= '0;
      hold_q <= '0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
      hold_q <= hold_d;
    end
  end

  // Next-state and datapath update; redirect always beats stall
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    hold_d  = hold_q;
    case (state_q)
      S_FETCH: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            pc_d = redirect_pc;
          end else begin
            pend_d  = redirect_pc;
            state_d = S_DRAIN;
          end
        end else if (imem_ack) begin
          if (stall_id) begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (!stall_id) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          pc_d    = redirect_valid ? redirect_pc : pend_q;
          state_d = S_FETCH;
        end else if (redirect_valid) begin
          pend_d = redirect_pc;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Memory request and IF/ID write; squashed slots are written as bubbles
  always_comb begin
    imem_req        = (state_q != S_HOLD);
    imem_addr       = pc_q;
    pc_write        = 1'b0;
    if_reg_in.pc    = IF_XLEN'(pc_q);
    if_reg_in.instr = NOP;
    if_reg_in.valid = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redirect_valid) begin
          pc_write = 1'b1;
        end else if (!stall_id) begin
          pc_write = 1'b1;
          if (imem_ack) begin
            if_reg_in.instr = imem_rdata;
            if_reg_in.valid = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_write = 1'b1;
        end else if (!stall_id) begin
          pc_write        = 1'b1;
          if_reg_in.instr = hold_q;
          if_reg_in.valid = 1'b1;
        end
      end
      S_DRAIN: pc_write = 1'b1;
      default: pc_write = 1'b0;
    endcase
    // No IF/ID writes while reset is held
    if (reset) begin
      pc_write        = 1'b0;
      if_reg_in.valid = 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_evt;
  logic bubble_evt;

  assign fetch_evt  = pc_write &  if_reg_in.valid;
  assign bubble_evt = pc_write & ~if_reg_in.valid;

  sat_counter #(.WIDTH(32)) u_perf_fetch (
    .clk   (clk),
    .reset (reset),
    .inc   (fetch_evt),
    .cnt   (perf_fetch_cnt)
  );

  sat_counter #(.WIDTH(32)) u_perf_bubble (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_evt),
    .cnt   (perf_bubble_cnt)
  );
`endif

endmodule
